mmcm_drp_reconfig: RTL and testbench

- Runtime reconfiguration sequencer for the system MMCM; switches the pixel/system clock pair between video modes without a bitstream change.
- Takes a mode index, holds the MMCM in reset and rewrites its clock-divider registers over the DRP port by read-modify-write.
- Then releases reset, waits for lock and reports done or error.
- Sits beside the MMCM in the top-level clock subsystem and runs on the 100 MHz input clock, which is also DCLK.

---
 rtl/mmcm_drp_pkg.sv | 53 +++++
 rtl/mmcm_drp_rom.sv | 23 ++
 rtl/mmcm_drp_reconfig.sv | 154 +++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_drp_pkg.sv
// rtl/mmcm_drp_pkg.sv - shared types and DRP divider table for the MMCM reconfiguration sequencer
package mmcm_drp_pkg;

  localparam int ROM_MODES = 4;
  localparam int ROM_REGS  = 8;

  // One read-modify-write: bits set in mask are kept from the readback,
  // all other bits come from data.
  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } drp_entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ASSERT_RST,
    ST_READ,
    ST_WAIT_RD,
    ST_WRITE,
    ST_WAIT_WR,
    ST_NEXT,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_ERROR
  } state_t;

  // Register order per mode: CLKOUT0 reg1/reg2, CLKOUT1 reg1/reg2,
  // CLKFBOUT reg1/reg2, DIVCLK, power.
  // mode 0: VCO 742.5 MHz (D=5, M=37.125), O0=5 -> 148.5, O1=15 -> 49.5
  // mode 1: VCO 742.5 MHz (D=5, M=37.125), O0=10 -> 74.25, O1=30 -> 24.75
  // mode 2: VCO 1080 MHz (D=5, M=54), O0=10 -> 108, O1=30 -> 36
  // mode 3: VCO 1000 MHz (D=5, M=50), O0=10 -> 100, O1=40 -> 25
  localparam drp_entry_t MODE_TABLE [ROM_MODES][ROM_REGS] = '{
    '{ '{7'h08, 16'h1000, 16'h00C2}, '{7'h09, 16'h8000, 16'h0080},
       '{7'h0A, 16'h1000, 16'h0207}, '{7'h0B, 16'h8000, 16'h0080},
       '{7'h14, 16'h1000, 16'h04D2}, '{7'h15, 16'h8000, 16'h1880},
       '{7'h16, 16'hC000, 16'h20C2}, '{7'h28, 16'h0000, 16'hFFFF} },
    '{ '{7'h08, 16'h1000, 16'h0145}, '{7'h09, 16'h8000, 16'h0000},
       '{7'h0A, 16'h1000, 16'h03CF}, '{7'h0B, 16'h8000, 16'h0000},
       '{7'h14, 16'h1000, 16'h04D2}, '{7'h15, 16'h8000, 16'h1880},
       '{7'h16, 16'hC000, 16'h20C2}, '{7'h28, 16'h0000, 16'hFFFF} },
    '{ '{7'h08, 16'h1000, 16'h0145}, '{7'h09, 16'h8000, 16'h0000},
       '{7'h0A, 16'h1000, 16'h03CF}, '{7'h0B, 16'h8000, 16'h0000},
       '{7'h14, 16'h1000, 16'h06DB}, '{7'h15, 16'h8000, 16'h0000},
       '{7'h16, 16'hC000, 16'h20C2}, '{7'h28, 16'h0000, 16'hFFFF} },
    '{ '{7'h08, 16'h1000, 16'h0145}, '{7'h09, 16'h8000, 16'h0000},
       '{7'h0A, 16'h1000, 16'h0514}, '{7'h0B, 16'h8000, 16'h0000},
       '{7'h14, 16'h1000, 16'h0659}, '{7'h15, 16'h8000, 16'h0000},
       '{7'h16, 16'hC000, 16'h20C2}, '{7'h28, 16'h0000, 16'hFFFF} }
  };

endpackage

// File: rtl/mmcm_drp_rom.sv
// rtl/mmcm_drp_rom.sv - combinational (mode, register index) to DRP entry lookup
module mmcm_drp_rom
  import mmcm_drp_pkg::*;
#(
  parameter int MODE_W = 2,
  parameter int IDX_W  = 3
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [IDX_W-1:0]  reg_idx,
  output drp_entry_t        entry
);

  logic [1:0] mode_i;
  logic [2:0] idx_i;

  // Table lookup; indices are resized to the fixed table dimensions.
  always_comb begin
    mode_i = 2'(mode);
    idx_i  = 3'(reg_idx);
    entry  = MODE_TABLE[mode_i][idx_i];
  end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// rtl/mmcm_drp_reconfig.sv - MMCM divider reprogramming sequencer over DRP
module mmcm_drp_reconfig
  import mmcm_drp_pkg::*;
#(
  parameter int NUM_MODES    = 4,
  parameter int NUM_REGS     = 8,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int DRDY_TIMEOUT = 64,
  parameter int MODE_W       = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk_in_100,
  input  logic              reset_n,
  input  logic              reconfig_req,
  input  logic [MODE_W-1:0] mode_sel,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [MODE_W-1:0] current_mode,
  output logic              locked,
  output logic              mmcm_rst,
  output logic [6:0]        drp_daddr,
  output logic [15:0]       drp_di,
  output logic              drp_den,
  output logic              drp_dwe,
  input  logic [15:0]       drp_do,
  input  logic              drp_drdy,
  input  logic              mmcm_locked
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DT_W  = $clog2(DRDY_TIMEOUT + 1);
  localparam int LT_W  = $clog2(LOCK_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [MODE_W-1:0] mode_q;
  logic [IDX_W-1:0]  reg_idx;
  logic [DT_W-1:0]   drdy_tmr;
  logic [LT_W-1:0]   lock_tmr;
  logic [1:0]        lock_sync;
  logic              lock_s;
  logic              accept;
  logic              mode_ok;
  drp_entry_t        entry;

  mmcm_drp_rom #(.MODE_W(MODE_W), .IDX_W(IDX_W)) u_rom (
    .mode    (mode_q),
    .reg_idx (reg_idx),
    .entry   (entry)
  );

  assign lock_s = lock_sync[1];
  assign locked = lock_s & ~busy;

  // Two-flop synchroniser for the raw MMCM LOCKED.
  always_ff @(posedge clk_in_100 or negedge reset_n) begin
    if (!reset_n) lock_sync <= 2'b00;
    else          lock_sync <= {lock_sync[0], mmcm_locked};
  end

  // FSM state register.
  always_ff @(posedge clk_in_100 or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode plus DRP strobes; den is a state decode so it can only
  // be high in READ or WRITE, never while a response is outstanding.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drp_den   = 1'b0;
    drp_dwe   = 1'b0;
    drp_daddr = '0;
    mode_ok   = (int'(mode_sel) < NUM_MODES);
    if (state inside {ST_READ, ST_WAIT_RD, ST_WRITE, ST_WAIT_WR}) drp_daddr = entry.addr;
    case (state)
      ST_IDLE: begin
        if (reconfig_req) begin
          accept    = 1'b1;
          state_nxt = mode_ok ? ST_ASSERT_RST : ST_ERROR;
        end
      end
      ST_ASSERT_RST: state_nxt = ST_READ;
      ST_READ: begin
        drp_den   = 1'b1;
        state_nxt = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (drp_drdy) state_nxt = ST_WRITE;
        else if (drdy_tmr == DT_W'(DRDY_TIMEOUT - 1)) state_nxt = ST_ERROR;
      end
      ST_WRITE: begin
        drp_den   = 1'b1;
        drp_dwe   = 1'b1;
        state_nxt = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (drp_drdy) state_nxt = ST_NEXT;
        else if (drdy_tmr == DT_W'(DRDY_TIMEOUT - 1)) state_nxt = ST_ERROR;
      end
      ST_NEXT: state_nxt = (reg_idx == IDX_W'(NUM_REGS - 1)) ? ST_RELEASE : ST_READ;
      ST_RELEASE: state_nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) state_nxt = ST_IDLE;
        else if (lock_tmr == LT_W'(LOCK_TIMEOUT - 1)) state_nxt = ST_ERROR;
      end
      ST_ERROR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sequencing datapath: mode capture, register index, timers and merged write data.
  always_ff @(posedge clk_in_100 or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= '0;
      reg_idx  <= '0;
      drdy_tmr <= '0;
      lock_tmr <= '0;
      drp_di   <= '0;
    end else begin
      if (accept) begin
        mode_q  <= mode_sel;
        reg_idx <= '0;
      end
      if (state == ST_NEXT && state_nxt == ST_READ) reg_idx <= reg_idx + 1'b1;
      if (state == ST_READ || state == ST_WRITE) drdy_tmr <= '0;
      else if (state == ST_WAIT_RD || state == ST_WAIT_WR) drdy_tmr <= drdy_tmr + 1'b1;
      if (state == ST_WAIT_RD && drp_drdy)
        drp_di <= (drp_do & entry.mask) | (entry.data & ~entry.mask);
      if (state == ST_RELEASE) lock_tmr <= '0;
      else if (state == ST_WAIT_LOCK && lock_tmr != LT_W'(LOCK_TIMEOUT)) lock_tmr <= lock_tmr + 1'b1;
    end
  end

  // Status outputs and the registered MMCM reset, all driven from the next state.
  always_ff @(posedge clk_in_100 or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      current_mode <= '0;
      mmcm_rst     <= 1'b0;
    end else begin
      busy     <= !(state_nxt inside {ST_IDLE, ST_ERROR});
      mmcm_rst <= state_nxt inside {ST_ASSERT_RST, ST_READ, ST_WAIT_RD,
                                    ST_WRITE, ST_WAIT_WR, ST_NEXT};
      done     <= (state == ST_WAIT_LOCK) && lock_s;
      if (state == ST_WAIT_LOCK && lock_s) current_mode <= mode_q;
      if (state_nxt == ST_ERROR) error <= 1'b1;
      else if (accept)           error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// tb/tb_mmcm_drp_reconfig.sv - scoreboard bench for the MMCM DRP reconfiguration sequencer
module tb_mmcm_drp_reconfig;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reconfig_req;
  logic [1:0]  mode_sel;
  logic        busy, done, error, locked, mmcm_rst;
  logic [1:0]  current_mode;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        mmcm_locked;

  mmcm_drp_reconfig #(
    .NUM_MODES(3), .NUM_REGS(8), .LOCK_TIMEOUT(1000), .DRDY_TIMEOUT(64)
  ) dut (
    .clk_in_100(clk), .reset_n(reset_n), .reconfig_req(reconfig_req), .mode_sel(mode_sel),
    .busy(busy), .done(done), .error(error), .current_mode(current_mode), .locked(locked),
    .mmcm_rst(mmcm_rst), .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_locked(mmcm_locked)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [6:0] addr; logic [15:0] di; } drp_exp_t;
  typedef struct packed { logic is_err; logic [1:0] mode; } evt_t;

  drp_exp_t drp_q[$];
  evt_t     evt_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, den_cyc = 0, err_cyc = 0, rel_cyc = 0, n_wr = 0;
  logic err_prev = 1'b0, rst_prev = 1'b0, rst_seen = 1'b0;
  logic drp_mute = 1'b0, lock_hold = 1'b0;
  int drdy_delay = 2;

  // Expected write data with the DRP model returning 16'h5A5A on every read:
  // (16'h5A5A & mask) | data, worked out by hand per register.
  logic [6:0]  exp_addr [8];
  logic [15:0] exp_di [2][8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_seq(input int m, input int nregs);
    for (int i = 0; i < nregs; i++) begin
      drp_q.push_back('{1'b0, exp_addr[i], 16'h0000});
      drp_q.push_back('{1'b1, exp_addr[i], exp_di[m][i]});
    end
  endtask

  task automatic request(input logic [1:0] m);
    @(posedge clk); #1;
    reconfig_req = 1'b1;
    mode_sel     = m;
    @(posedge clk); #1;
    reconfig_req = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (drp_q.size() == 0 && evt_q.size() == 0) break;
    end
    n_cmp++;
    if (i >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d DRP and %0d status expectations pending after %0d cycles",
               name, drp_q.size(), evt_q.size(), budget);
      drp_q.delete();
      evt_q.delete();
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // DRP slave model: drdy with read data drdy_delay cycles after each den.
  initial begin
    int cnt;
    cnt = -1;
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      drp_do   = 16'h0000;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drp_drdy = 1'b1;
          drp_do   = 16'h5A5A;
          cnt      = -1;
        end
      end
      if (drp_den && !drp_mute && reset_n) cnt = drdy_delay;
    end
  end

  // MMCM lock model: unlocked while in reset, locks 50 cycles after release.
  initial begin
    int lk_cnt;
    lk_cnt = 0;
    mmcm_locked = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mmcm_rst) begin
        mmcm_locked = 1'b0;
        lk_cnt      = 0;
      end else if (!mmcm_locked && !lock_hold) begin
        lk_cnt++;
        if (lk_cnt >= 50) mmcm_locked = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every DRP access and every done/error event.
  initial begin
    drp_exp_t e;
    evt_t     v;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        err_prev = 1'b0;
        rst_prev = 1'b0;
      end else begin
        if (mmcm_rst) rst_seen = 1'b1;
        if (rst_prev && !mmcm_rst) rel_cyc = cyc;
        if (drp_den) begin
          den_cyc = cyc;
          if (drp_dwe) n_wr++;
          chk("den_rst_held", mmcm_rst, 1);
          chk("den_locked_low", locked, 0);
          if (drp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL den_unexpected: addr %0h we %0b, expected no DRP access", drp_daddr, drp_dwe);
          end else begin
            e = drp_q.pop_front();
            chk("drp_addr", drp_daddr, e.addr);
            chk("drp_we", drp_dwe, e.we);
            if (e.we) chk("drp_di", drp_di, e.di);
          end
        end
        if (done || (error && !err_prev)) begin
          if (!done) err_cyc = cyc;
          if (evt_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL evt_unexpected: done %0b error %0b, expected no status event", done, error);
          end else begin
            v = evt_q.pop_front();
            chk("evt_kind_is_err", !done, v.is_err);
            chk("evt_current_mode", current_mode, v.mode);
            chk("evt_busy", busy, 0);
            chk("evt_mmcm_rst", mmcm_rst, 0);
          end
        end
        err_prev = error;
        rst_prev = mmcm_rst;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, i;
    exp_addr  = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15, 7'h16, 7'h28};
    exp_di[0] = '{16'h10C2, 16'h0080, 16'h1207, 16'h0080, 16'h14D2, 16'h1880, 16'h60C2, 16'hFFFF};
    exp_di[1] = '{16'h1145, 16'h0000, 16'h13CF, 16'h0000, 16'h14D2, 16'h1880, 16'h60C2, 16'hFFFF};
    reset_n      = 1'b0;
    reconfig_req = 1'b0;
    mode_sel     = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_current_mode", current_mode, 0);
    chk("rst_mmcm_rst", mmcm_rst, 0);
    chk("rst_den", drp_den, 0);
    chk("rst_dwe", drp_dwe, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_di", drp_di, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);

    // Valid mode 1: eight RMW pairs in ROM order, then lock and done
    push_seq(1, 8);
    evt_q.push_back('{1'b0, 2'd1});
    request(2'd1);
    chk("t1_busy_after_accept", busy, 1);
    wait_drain(1000, "t1");
    repeat (3) @(negedge clk);
    chk("t1_locked", locked, 1);
    chk("t1_current_mode", current_mode, 1);

    // Invalid mode 3 with three modes configured
    rst_seen = 1'b0;
    evt_q.push_back('{1'b1, 2'd1});
    request(2'd3);
    chk("t2_error_next_cycle", error, 1);
    chk("t2_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("t2_mmcm_rst_never", rst_seen, 0);
    wait_drain(20, "t2");

    // DRP never answers: error after 64 cycles in WAIT_RD
    drp_mute = 1'b1;
    drp_q.push_back('{1'b0, 7'h08, 16'h0000});
    evt_q.push_back('{1'b1, 2'd1});
    request(2'd2);
    chk("t3_error_cleared_on_accept", error, 0);
    wait_drain(300, "t3");
    chk("t3_drdy_timeout_cycles", err_cyc - den_cyc, 65);
    chk("t3_busy", busy, 0);
    drp_mute = 1'b0;
    repeat (70) @(negedge clk);

    // Lock withheld: error after 1000 WAIT_LOCK cycles, no done
    lock_hold = 1'b1;
    push_seq(0, 8);
    evt_q.push_back('{1'b1, 2'd1});
    request(2'd0);
    wait_drain(3000, "t4");
    chk("t4_lock_timeout_cycles", err_cyc - rel_cyc, 1001);
    chk("t4_current_mode", current_mode, 1);
    lock_hold = 1'b0;
    repeat (70) @(negedge clk);

    // Reset asserted during the 4th register write
    push_seq(1, 4);
    request(2'd1);
    for (i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (drp_q.size() == 0) break;
    end
    chk("t5_reached_4th_write", (i < 500) && drp_den && drp_dwe, 1);
    drp_q.delete();
    reset_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_error", error, 0);
    chk("t5_current_mode", current_mode, 0);
    chk("t5_mmcm_rst", mmcm_rst, 0);
    chk("t5_den", drp_den, 0);
    chk("t5_dwe", drp_dwe, 0);
    chk("t5_daddr", drp_daddr, 0);
    chk("t5_di", drp_di, 0);
    chk("t5_locked", locked, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_idle_after_reset", busy, 0);

    // Full run from reg 0 with a stray request during WAIT_WR
    push_seq(1, 8);
    evt_q.push_back('{1'b0, 2'd1});
    wr0 = n_wr;
    request(2'd1);
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (drp_den && drp_dwe) break;
    end
    chk("t6_first_write_seen", i < 200, 1);
    request(2'd2);
    wait_drain(1500, "t6");
    repeat (60) @(negedge clk);
    chk("t6_write_count", n_wr - wr0, 8);
    chk("t6_current_mode", current_mode, 1);
    chk("t6_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
